epu_dma_master: RTL

AXI master that feeds the EPU. Bursts raw YUV words out of system memory and replays them as write bursts into a destination window, normally the EPU raw-data port 0x00100000. It sits on a master port of the AXI interconnect, opposite the EPU slave wrapper. It offloads the CPU from word-by-word PIO transfers into the H.264 encoder.

---
 rtl/epu_dma_master.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/epu_dma_master.sv
// ============================================================================
// epu_dma_master
// ----------------------------------------------------------------------------
// AXI master that feeds the EPU. It reads raw YUV words from system memory in
// INCR bursts into a small internal buffer, then writes each buffer out as one
// write burst to a destination window. By default that window is the EPU
// raw-data FIFO port. Only one AXI transaction is in flight at any time.
//
// Build option:
//   DMA_DST_INC_EN  defined   : AWBURST=INCR. The destination advances after
//                               every burst, and bursts also split at the
//                               destination's 4 KB boundaries. Use this for
//                               memory-to-memory copies.
//                   undefined : AWBURST=FIXED. Every burst goes to the same
//                               destination address (the EPU FIFO).
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start                 one-cycle job request; honoured only when idle
//   src_addr, dst_addr    byte addresses; bits [1:0] are ignored
//   word_cnt              number of 32-bit words to move
//   busy                  job in progress (RADDR..WRESP)
//   done_irq              sticky completion flag, cleared by the next start
//   err                   sticky error flag (non-OKAY RRESP/BRESP)
//   AR*/R*/AW*/W*/B*      AXI4 master channels: 32-bit data, 4-bit IDs
// ============================================================================
`timescale 1ns/1ps

module epu_dma_master #(
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] AXI_ID    = 4'd2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_cnt,
    output logic        busy,
    output logic        done_irq,
    output logic        err,

    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,

    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,

    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,

    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,

    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    localparam int          IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [15:0] MB16  = 16'(MAX_BURST);
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [2:0]  SIZE_WORD   = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] rem_q;
    logic [4:0]  blen_q;
    logic [4:0]  beat;
    logic        err_q;
    logic        done_q;
    logic [31:0] mem_buf [0:MAX_BURST-1];

    logic [4:0]       blen_c;
    logic [15:0]      blen_full;
    logic [10:0]      w4k_src;
    logic [10:0]      w4k_dst;
    logic [IDX_W-1:0] beat_idx;
    logic             wlast_c;

    // IDs are not checked, and the low address bits are forced to zero.
    logic unused_bits;
    assign unused_bits = ^{RID, BID, src_addr[1:0], dst_addr[1:0]};

    assign beat_idx = beat[IDX_W-1:0];
    assign wlast_c  = (beat == (blen_q - 5'd1));
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done_irq = done_q;
    assign err      = err_q;

    // Burst length: the smallest of the words remaining, the buffer depth, and
    // the words left before the next 4 KB page. No burst may cross a page.
    always_comb begin
        w4k_src   = 11'd1024 - {1'b0, src_q[11:2]};
        w4k_dst   = 11'd1024 - {1'b0, dst_q[11:2]};
        blen_full = rem_q;
        if ({5'd0, w4k_src} < blen_full)
            blen_full = {5'd0, w4k_src};
`ifdef DMA_DST_INC_EN
        if ({5'd0, w4k_dst} < blen_full)
            blen_full = {5'd0, w4k_dst};
`endif
        if (MB16 < blen_full)
            blen_full = MB16;
        blen_c = 5'(blen_full);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next state and AXI outputs. Every output is decoded from the registered
    // state only, so no READY input can reach a VALID output combinationally.
    always_comb begin
        state_n = state;
        ARID    = AXI_ID;
        ARADDR  = 32'd0;
        ARLEN   = 4'd0;
        ARSIZE  = 3'd0;
        ARBURST = 2'd0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        AWID    = AXI_ID;
        AWADDR  = 32'd0;
        AWLEN   = 4'd0;
        AWSIZE  = 3'd0;
        AWBURST = 2'd0;
        AWVALID = 1'b0;
        WDATA   = 32'd0;
        WSTRB   = 4'd0;
        WLAST   = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start)
                    state_n = (word_cnt == 16'd0) ? S_DONE : S_RADDR;
            end
            S_RADDR: begin
                ARVALID = 1'b1;
                ARADDR  = src_q;
                ARLEN   = 4'(blen_c - 5'd1);
                ARSIZE  = SIZE_WORD;
                ARBURST = BURST_INCR;
                if (ARREADY)
                    state_n = S_RDATA;
            end
            S_RDATA: begin
                RREADY = 1'b1;
                // An error anywhere in the burst cancels the write phase.
                // The burst is still drained to RLAST first.
                if (RVALID && RLAST)
                    state_n = (err_q || (RRESP != 2'b00)) ? S_DONE : S_WADDR;
            end
            S_WADDR: begin
                AWVALID = 1'b1;
                AWADDR  = dst_q;
                AWLEN   = 4'(blen_q - 5'd1);
                AWSIZE  = SIZE_WORD;
`ifdef DMA_DST_INC_EN
                AWBURST = BURST_INCR;
`else
                AWBURST = BURST_FIXED;
`endif
                if (AWREADY)
                    state_n = S_WDATA;
            end
            S_WDATA: begin
                WVALID = 1'b1;
                WDATA  = mem_buf[beat_idx];
                WSTRB  = 4'hF;
                WLAST  = wlast_c;
                if (WREADY && wlast_c)
                    state_n = S_WRESP;
            end
            S_WRESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    if (BRESP != 2'b00)
                        state_n = S_DONE;
                    else if (rem_q == {11'd0, blen_q})
                        state_n = S_DONE;
                    else
                        state_n = S_RADDR;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                err_q  <= 1'b0;
                done_q <= 1'b0;
            end
            if ((state == S_RDATA) && RVALID && (RRESP != 2'b00))
                err_q <= 1'b1;
            if ((state == S_WRESP) && BVALID && (BRESP != 2'b00))
                err_q <= 1'b1;
            if (state == S_DONE)
                done_q <= 1'b1;
        end
    end

    // Job registers and the burst buffer. These are not reset: each one is
    // loaded again before it is used, whether by the next start or by the
    // next burst.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    src_q <= {src_addr[31:2], 2'b00};
                    dst_q <= {dst_addr[31:2], 2'b00};
                    rem_q <= word_cnt;
                end
            end
            S_RADDR: begin
                beat <= 5'd0;
                if (ARREADY)
                    blen_q <= blen_c;
            end
            S_RDATA: begin
                if (RVALID) begin
                    mem_buf[beat_idx] <= RDATA;
                    beat <= beat + 5'd1;
                    if (RLAST)
                        src_q <= src_q + {25'd0, blen_q, 2'b00};
                end
            end
            S_WADDR: begin
                beat <= 5'd0;
            end
            S_WDATA: begin
                if (WREADY)
                    beat <= beat + 5'd1;
            end
            S_WRESP: begin
                if (BVALID) begin
                    rem_q <= rem_q - {11'd0, blen_q};
`ifdef DMA_DST_INC_EN
                    dst_q <= dst_q + {25'd0, blen_q, 2'b00};
`endif
                end
            end
            default: begin
            end
        endcase
    end

endmodule
